// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the instruction encoder: RV32I opcode and funct3
// constants, the beat-kind enum, the encoder FSM state enum, and the two
// field-packing helpers (ADDI I-type, BNE B-type).
// No ports; imported with "import rv_pkg::*;".
// -----------------------------------------------------------------------------
package rv_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    typedef enum logic {
        KIND_ADDI = 1'b0,
        KIND_BNE  = 1'b1
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // I-type: imm[11:0] | rs1 | funct3 | rd | opcode
    function automatic logic [31:0] enc_addi(input logic [4:0]  rd,
                                             input logic [4:0]  rs1,
                                             input logic [11:0] imm12);
        return {imm12, rs1, F3_ADDI, rd, OP_IMM};
    endfunction

    // B-type. The branch offset is always even, so the caller passes the
    // byte offset already shifted right by one: off[k] == imm[k+1].
    function automatic logic [31:0] enc_bne(input logic [4:0]  rs1,
                                            input logic [4:0]  rs2,
                                            input logic [11:0] off);
        return {off[11], off[9:4], rs2, rs1, F3_BNE, off[3:0], off[10], OP_BRANCH};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead head output.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (empties the FIFO)
//   push, din       write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   full, empty     occupancy flags
//   single          exactly one entry held (lets the owner see the last pop)
//   head            oldest entry, valid when !empty
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             single,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign single  = (cnt_q == CW'(1));
    assign head    = mem_q[rd_q];

    // A full FIFO never takes a push, even when it is popped the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Accepts ADDI / BNE field beats, packs them into 32-bit RV32I words, buffers
// them in a small FIFO and writes them to consecutive word addresses of an
// instruction memory, one word per cycle.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start, start_addr          session start pulse and byte base address
//   in_valid/in_ready          beat handshake
//   in_kind, in_rd, in_rs1,
//   in_rs2, in_imm, in_last    beat fields; in_last closes the session
//   mem_we, mem_addr, mem_wdata  instruction-memory write port
//   busy, done, err            session active, completion pulse,
//                              sticky misaligned-branch flag
//   word_count                 words written in the current/last session
// -----------------------------------------------------------------------------
module instr_encoder
    import rv_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_kind,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [12:0]   in_imm,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-2:0] word_count
);

    localparam int WCW = AW - 1;

    state_e         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           err_q, err_d;

    logic           accept;
    logic           is_bne;
    logic [31:0]    enc_word;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_single;
    logic [31:0]    fifo_head;

    assign is_bne   = (in_kind == KIND_BNE);
    assign in_ready = (state_q == ST_LOAD) && !fifo_full;
    assign accept   = in_valid && in_ready;

    assign busy       = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign mem_we     = busy && !fifo_empty;
    assign mem_addr   = addr_q;
    assign mem_wdata  = fifo_head;
    assign err        = err_q;
    assign word_count = wcnt_q;

    // A misaligned branch offset simply loses bit 0 here; err records it.
    assign enc_word = is_bne ? enc_bne(in_rs1, in_rs2, in_imm[12:1])
                             : enc_addi(in_rd, in_rs1, in_imm[11:0]);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (accept),
        .din    (enc_word),
        .pop    (mem_we),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .single (fifo_single),
        .head   (fifo_head)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;

        // Every write advances the address (wrapping) and the saturating count.
        if (mem_we) begin
            addr_d = addr_q + AW'(4);
            if (wcnt_q != '1) begin
                wcnt_d = wcnt_q + WCW'(1);
            end
        end

        if (accept && is_bne && in_imm[0]) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    addr_d  = {start_addr[AW-1:2], 2'b00};
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept && in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as the final pop empties the FIFO.
                if (fifo_empty || (mem_we && fifo_single)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Randomized and directed stimulus for instr_encoder, checked every cycle
// against a transaction-level model (expected-word queue plus session flags).
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int WCMAX = 127;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          in_valid;
    logic          in_ready;
    logic          in_kind;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [12:0]   in_imm;
    logic          in_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-2:0] word_count;

    instr_encoder #(
        .FIFO_DEPTH (DEPTH),
        .AW         (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
    } beat_t;

    beat_t       bq[$];
    logic [39:0] obs_wr[$];

    int n_vec;
    int n_miss;
    bit chk_en;

    // Model state
    logic [31:0]   exp_q[$];
    bit            m_busy, m_done, m_last, m_err;
    logic [AW-1:0] m_addr;
    int            m_wc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference encoding built from the instruction-format definitions with
    // plain integer arithmetic.
    function automatic logic [31:0] ref_word(input beat_t b);
        int unsigned w;
        int unsigned o;
        if (!b.kind) begin
            w = ((32'(b.imm) & 32'hFFF) << 20) + (32'(b.rs1) << 15)
              + (32'(b.rd) << 7) + 32'h13;
        end else begin
            o = 32'(b.imm) & 32'h1FFE;
            w = (((o >> 12) & 1) << 31) + (((o >> 5) & 63) << 25)
              + (32'(b.rs2) << 20) + (32'(b.rs1) << 15) + (1 << 12)
              + (((o >> 1) & 15) << 8) + (((o >> 11) & 1) << 7) + 32'h63;
        end
        return w;
    endfunction

    // One clock cycle: inputs are already driven; sample #1 after the falling
    // edge, compare, advance the model, then wait for the next falling edge.
    task automatic cyc(output bit acc);
        bit    e_we, e_rdy, b0, d0, last0, done_nxt;
        beat_t b;
        #1;
        b0    = m_busy;
        d0    = m_done;
        last0 = m_last;
        e_we  = m_busy && (exp_q.size() > 0);
        e_rdy = m_busy && !m_last && (exp_q.size() < DEPTH);
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("in_ready", 32'(in_ready), 32'(e_rdy));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("err", 32'(err), 32'(m_err));
            chk("word_count", 32'(word_count), 32'(m_wc));
            if (e_we && mem_we) begin
                chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                chk("mem_wdata", mem_wdata, exp_q[0]);
            end
        end
        if (mem_we === 1'b1) obs_wr.push_back({mem_addr, mem_wdata});
        acc = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            m_busy = 0; m_done = 0; m_last = 0; m_err = 0;
            m_addr = '0; m_wc = 0;
        end else begin
            done_nxt = 1'b0;
            if (e_we) begin
                void'(exp_q.pop_front());
                m_addr = m_addr + 8'd4;
                if (m_wc < WCMAX) m_wc++;
            end
            if (in_valid && e_rdy) begin
                acc    = 1'b1;
                b.kind = in_kind; b.rd = in_rd; b.rs1 = in_rs1;
                b.rs2  = in_rs2;  b.imm = in_imm;
                exp_q.push_back(ref_word(b));
                if (in_kind && in_imm[0]) m_err = 1;
                if (in_last) m_last = 1;
            end
            if (b0 && last0 && exp_q.size() == 0) begin
                m_busy   = 0;
                done_nxt = 1;
            end
            if (start && !b0 && !d0) begin
                m_busy = 1; m_last = 0; m_err = 0; m_wc = 0;
                m_addr = {start_addr[AW-1:2], 2'b00};
            end
            m_done = done_nxt;
        end
        @(negedge clk);
    endtask

    task automatic add_beat(input bit kind, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [12:0] imm);
        beat_t b;
        b.kind = kind; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
        bq.push_back(b);
    endtask

    task automatic add_random(input int n);
        for (int i = 0; i < n; i++) begin
            add_beat(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 13'($urandom));
        end
    endtask

    // Run one session over the beats in bq. pv: percent of cycles in_valid is
    // offered. rst_at: LOAD-phase cycle to assert reset (-1 = never).
    // extra_start: pulse start during LOAD. rst_drain: reset in first drain cycle.
    task automatic session(input logic [AW-1:0] sa, input int pv, input int rst_at,
                           input bit extra_start, input bit rst_drain);
        bit acc;
        int idx;
        int c;
        int k;
        bit aborted;
        obs_wr.delete();
        start = 1'b1; start_addr = sa;
        cyc(acc);
        start = 1'b0;
        idx = 0; c = 0; aborted = 0;
        while (idx < bq.size() && c < 2000) begin
            in_valid = ($urandom_range(99) < pv);
            in_kind  = bq[idx].kind;
            in_rd    = bq[idx].rd;
            in_rs1   = bq[idx].rs1;
            in_rs2   = bq[idx].rs2;
            in_imm   = bq[idx].imm;
            in_last  = (idx == bq.size() - 1);
            if (extra_start && c == 1) begin
                start = 1'b1; start_addr = ~sa;
            end
            if (c == rst_at) rst_n = 1'b0;
            cyc(acc);
            start = 1'b0;
            if (!rst_n) begin
                rst_n = 1'b1; aborted = 1; break;
            end
            if (acc) idx++;
            c++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("load_timeout", 32'(c < 2000), 32'd1);
        if (rst_drain && !aborted && m_busy) begin
            rst_n = 1'b0;
            cyc(acc);
            rst_n = 1'b1;
        end
        k = 0;
        while ((m_busy || m_done) && k < 300) begin
            cyc(acc);
            k++;
        end
        chk("drain_timeout", 32'(k < 300), 32'd1);
        cyc(acc);
        bq.delete();
    endtask

    initial begin : main
        bit acc;
        n_vec = 0; n_miss = 0; chk_en = 0;
        exp_q.delete();
        m_busy = 0; m_done = 0; m_last = 0; m_err = 0; m_addr = '0; m_wc = 0;
        rst_n = 1'b0; start = 1'b0; start_addr = '0;
        in_valid = 1'b0; in_kind = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_last = 1'b0;
        @(negedge clk);
        cyc(acc);
        chk_en = 1;
        cyc(acc);
        rst_n = 1'b1;
        cyc(acc);

        // Single ADDI at address 0
        add_beat(1'b0, 5'd1, 5'd0, 5'd0, 13'd5);
        session(8'h00, 100, -1, 0, 0);
        chk("addi_cnt", 32'(obs_wr.size()), 32'd1);
        if (obs_wr.size() > 0) chk("addi_word", {24'd0, obs_wr[0][39:32]} ^ 32'd0 | obs_wr[0][31:0], 32'h00500093);
        chk("addi_wc", 32'(word_count), 32'd1);

        // BNE with a negative aligned offset
        add_beat(1'b1, 5'd0, 5'd1, 5'd2, 13'h1FF8);
        session(8'h10, 100, -1, 0, 0);
        if (obs_wr.size() > 0) chk("bne_word", obs_wr[0][31:0], 32'hFE209CE3);
        chk("bne_err", 32'(err), 32'd0);

        // Misaligned BNE: bit 0 dropped, err sticky past done
        add_beat(1'b1, 5'd0, 5'd3, 5'd4, 13'h0009);
        session(8'h20, 100, -1, 0, 0);
        if (obs_wr.size() > 0) chk("bne_mis_word", obs_wr[0][31:0], 32'h00419463);
        chk("err_sticky", 32'(err), 32'd1);
        cyc(acc);
        cyc(acc);
        chk("err_hold", 32'(err), 32'd1);

        // Address wrap across 0xFC -> 0x00
        add_beat(1'b0, 5'd2, 5'd2, 5'd0, 13'd1);
        add_beat(1'b0, 5'd3, 5'd3, 5'd0, 13'd2);
        add_beat(1'b0, 5'd4, 5'd4, 5'd0, 13'd3);
        session(8'hF8, 100, -1, 0, 0);
        chk("wrap_cnt", 32'(obs_wr.size()), 32'd3);
        if (obs_wr.size() == 3) begin
            chk("wrap_a0", 32'(obs_wr[0][39:32]), 32'hF8);
            chk("wrap_a1", 32'(obs_wr[1][39:32]), 32'hFC);
            chk("wrap_a2", 32'(obs_wr[2][39:32]), 32'h00);
        end

        // Back-to-back burst with a start pulse during LOAD (ignored)
        add_random(8);
        session(8'h43, 100, -1, 1, 0);
        chk("burst_cnt", 32'(obs_wr.size()), 32'd8);

        // Reset in DRAIN and reset mid-LOAD
        add_random(6);
        session(8'h80, 100, -1, 0, 1);
        add_random(6);
        session(8'h90, 70, 3, 0, 0);

        // Saturating word count
        for (int i = 0; i < 135; i++) add_beat(1'b0, 5'(i), 5'(i + 1), 5'd0, 13'(i));
        session(8'h00, 100, -1, 0, 0);
        chk("wc_sat", 32'(word_count), 32'(WCMAX));

        // Random sessions
        for (int s = 0; s < 12; s++) begin
            add_random($urandom_range(1, 10));
            session(8'($urandom), $urandom_range(30, 100), -1, 1'($urandom_range(0, 3) == 0), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of encoded words buffered ahead of the memory write port (power of two, >=2).
REQ-002 Parameter AW, default 8, byte-address width of the instruction-memory write port.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 start  input  1  one-cycle pulse; begins a load session at start_addr.
REQ-006 start_addr  input  AW  byte base address of the session; bits [1:0] ignored (forced 0).
REQ-007 in_valid  input  1  field beat present.
REQ-008 in_ready  output  1  beat can be accepted this cycle.
REQ-009 in_kind  input  1  0 = ADDI, 1 = BNE.
REQ-010 in_rd, in_rs1, in_rs2  input  5 each  register fields (in_rd unused for BNE; in_rs2 unused for ADDI).
REQ-011 in_imm  input  13  ADDI uses [11:0]; BNE uses [12:0] as signed byte offset.
REQ-012 in_last  input  1  marks final beat of the session.
REQ-013 mem_we, mem_addr, mem_wdata  output  1/AW/32  instruction-memory write port.
REQ-014 busy, done, err  output  1 each  session active; one-cycle completion pulse; sticky misaligned-branch flag.
REQ-015 word_count  output  AW-1  words written in the current/last session.

Function
REQ-016 FSM states IDLE, LOAD, DRAIN, DONE; busy = 1 in LOAD and DRAIN.
REQ-017 IDLE -> LOAD on start; start_addr latched into address counter, word_count and err cleared.
REQ-018 start while not in IDLE is ignored.
REQ-019 in_ready = 1 only in LOAD with FIFO not full; a beat is accepted when in_valid && in_ready.
REQ-020 No push when FIFO is full, even if a pop occurs the same cycle.
REQ-021 ADDI encoding: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
REQ-022 BNE encoding: {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}.
REQ-023 BNE with in_imm[0]=1: encoded with bit 0 dropped, err set, held until next start.
REQ-024 Encoding is combinational on accepted fields; the encoded word enters the FIFO at the accepting edge.
REQ-025 mem_we = FIFO not empty AND state in {LOAD, DRAIN}; mem_wdata = FIFO head; mem_addr = address counter.
REQ-026 Each mem_we cycle pops the FIFO, adds 4 to the address counter, increments word_count.
REQ-027 Latency: beat accepted in cycle N with FIFO empty appears on mem_* in cycle N+1.
REQ-028 Address counter wraps modulo 2^AW (e.g. AW=8: 0xFC -> 0x00); no error on wrap.
REQ-029 word_count saturates at its maximum.
REQ-030 Accepting a beat with in_last=1: LOAD -> DRAIN; in_ready = 0 thereafter.
REQ-031 DRAIN -> DONE on the cycle the FIFO becomes empty after the final pop; DONE lasts one cycle with done=1, then IDLE.
REQ-032 word_count and err hold their values in IDLE until the next start.

Reset
REQ-033 rst_n=0 at any edge, including mid-session: state IDLE, FIFO emptied, address counter 0, word_count 0, err 0.
REQ-034 Consequently in_ready, mem_we, busy, done are 0 in the cycle after reset; unwritten buffered words are discarded.

Structure
REQ-035 Shared package rv_pkg holds opcode constants (OP_IMM 7'b0010011, OP_BRANCH 7'b1100011), funct3 constants (ADDI 000, BNE 001), the kind enum and the FSM state enum.
REQ-036 FIFO is a sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head), same clk/rst_n.

Verification
REQ-037 start, start_addr=0x00; one beat ADDI rd=1 rs1=0 imm=5 last=1 -> next cycle mem_we=1, addr=0x00, wdata=0x00500093; then done pulse, word_count=1.
REQ-038 BNE rs1=1 rs2=2 imm=-8 (0x1FF8) last=1 -> wdata=0xFE209CE3, err=0.
REQ-039 BNE imm=0x0009 -> word encoded as imm=8, err=1 sticky through done until next start.
REQ-040 start_addr=0xF8, three ADDI beats back-to-back -> addresses 0xF8, 0xFC, 0x00.
REQ-041 Write port held off by forcing in_valid bursts faster than drain with FIFO_DEPTH=4 -> in_ready drops when 4 entries held; no word lost or duplicated; order preserved.
REQ-042 rst_n=0 during DRAIN with 3 words buffered -> next cycle mem_we=0, busy=0, word_count=0; start during LOAD ignored.
